// File: rtl/bf16_addsub_pipe.sv
// Three-stage pipelined BF16 add/subtract unit with valid/ready flow control.
// Arithmetic: two guard bits during alignment, truncation, no rounding.
// Stage 1 aligns operands, stage 2 adds/subtracts magnitudes, stage 3 normalizes and packs.
// All stages advance together whenever the output slot is free or being consumed.

module bf16_addsub_pipe #(
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic [TAG_W-1:0] out_tag
);

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic adv;

    // Stage 1 registers: aligned magnitudes with guard bits
    logic             s1_valid_q;
    logic             s1_sign_a_q, s1_sign_b_q;
    logic [9:0]       s1_mag_a_q, s1_mag_b_q;
    logic [7:0]       s1_exp_q;
    logic [TAG_W-1:0] s1_tag_q;

    // Stage 2 registers: signed-magnitude sum
    logic             s2_valid_q;
    logic             s2_sign_q;
    logic [10:0]      s2_sum_q;
    logic [7:0]       s2_exp_q;
    logic [TAG_W-1:0] s2_tag_q;

    // Stage 3 registers drive the outputs directly
    logic             s3_valid_q;
    logic [15:0]      s3_sum_q;
    logic [TAG_W-1:0] s3_tag_q;

    assign adv       = !s3_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = s3_valid_q;
    assign out_sum   = s3_sum_q;
    assign out_tag   = s3_tag_q;

    // ------------------------------------------------------------------
    // Stage 1: unpack and align
    // ------------------------------------------------------------------
    logic       sign_a, sign_b;
    logic [7:0] exp_a, exp_b;
    logic [9:0] ext_a, ext_b;
    logic       a_exp_ge;
    logic [7:0] exp_diff;
    logic [9:0] s1_mag_a_d, s1_mag_b_d;
    logic [7:0] s1_exp_d;

    // Right shift that saturates to zero once every significant bit is gone.
    function automatic logic [9:0] align_shift(input logic [9:0] v, input logic [7:0] d);
        if (d >= 8'd10) begin
            return 10'd0;
        end
        return v >> d[3:0];
    endfunction

    // Unpack both operands and shift the one with the smaller exponent.
    always_comb begin
        sign_a   = in_a[15];
        sign_b   = in_b[15] ^ in_op;
        exp_a    = in_a[14:7];
        exp_b    = in_b[14:7];
        // Hidden bit is set only for normal (non-zero exponent) operands.
        ext_a    = {(exp_a != 8'd0), in_a[6:0], 2'b00};
        ext_b    = {(exp_b != 8'd0), in_b[6:0], 2'b00};
        a_exp_ge = (exp_a >= exp_b);
        exp_diff = a_exp_ge ? (exp_a - exp_b) : (exp_b - exp_a);
        if (a_exp_ge) begin
            s1_exp_d   = exp_a;
            s1_mag_a_d = ext_a;
            s1_mag_b_d = align_shift(ext_b, exp_diff);
        end else begin
            s1_exp_d   = exp_b;
            s1_mag_a_d = align_shift(ext_a, exp_diff);
            s1_mag_b_d = ext_b;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: add or subtract aligned magnitudes
    // ------------------------------------------------------------------
    logic        s2_sign_d;
    logic [10:0] s2_sum_d;

    // Same signs add; opposite signs subtract smaller from larger magnitude.
    always_comb begin
        s2_sign_d = 1'b0;
        s2_sum_d  = 11'd0;
        if (s1_sign_a_q == s1_sign_b_q) begin
            s2_sum_d  = {1'b0, s1_mag_a_q} + {1'b0, s1_mag_b_q};
            s2_sign_d = s1_sign_a_q;
        end else if (s1_mag_a_q > s1_mag_b_q) begin
            s2_sum_d  = {1'b0, s1_mag_a_q} - {1'b0, s1_mag_b_q};
            s2_sign_d = s1_sign_a_q;
        end else if (s1_mag_b_q > s1_mag_a_q) begin
            s2_sum_d  = {1'b0, s1_mag_b_q} - {1'b0, s1_mag_a_q};
            s2_sign_d = s1_sign_b_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalize and pack
    // ------------------------------------------------------------------
    logic [3:0]  lead_pos;
    logic        lead_found;
    logic [3:0]  norm_shift;
    logic [9:0]  norm_sig;
    logic [6:0]  res_man;
    logic [9:0]  res_exp;   // two extra bits catch overflow and negative wrap
    logic [15:0] s3_sum_d;

    // Locate the leading one, renormalize and apply overflow/underflow rules.
    always_comb begin
        lead_pos   = 4'd0;
        lead_found = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            if (!lead_found && s2_sum_q[i]) begin
                lead_pos   = 4'(i);
                lead_found = 1'b1;
            end
        end
        norm_shift = 4'd9 - lead_pos;
        norm_sig   = s2_sum_q[9:0] << norm_shift;
        if (s2_sum_q[10]) begin
            res_man = s2_sum_q[9:3];
            res_exp = {2'b00, s2_exp_q} + 10'd1;
        end else begin
            res_man = norm_sig[8:2];
            res_exp = {2'b00, s2_exp_q} - {6'd0, norm_shift};
        end

        if (s2_sum_q == 11'd0) begin
            s3_sum_d = 16'h0000;
        end else if (res_exp[9] || (res_exp == 10'd0)) begin
            s3_sum_d = 16'h0000;
        end else if (res_exp >= 10'd255) begin
            s3_sum_d = {s2_sign_q, 8'hFF, 7'h00};
        end else begin
            s3_sum_d = {s2_sign_q, res_exp[7:0], res_man};
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers: all stages shift together on adv, hold otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_a_q <= 1'b0;
            s1_sign_b_q <= 1'b0;
            s1_mag_a_q  <= 10'd0;
            s1_mag_b_q  <= 10'd0;
            s1_exp_q    <= 8'd0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_sum_q    <= 11'd0;
            s2_exp_q    <= 8'd0;
            s2_tag_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_sum_q    <= 16'h0000;
            s3_tag_q    <= '0;
        end else if (adv) begin
            // Empty input slots travel down as bubbles.
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_a_q <= sign_a;
                s1_sign_b_q <= sign_b;
                s1_mag_a_q  <= s1_mag_a_d;
                s1_mag_b_q  <= s1_mag_b_d;
                s1_exp_q    <= s1_exp_d;
                s1_tag_q    <= in_tag;
            end

            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q <= s2_sign_d;
                s2_sum_q  <= s2_sum_d;
                s2_exp_q  <= s1_exp_q;
                s2_tag_q  <= s1_tag_q;
            end

            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_sum_q <= s3_sum_d;
                s3_tag_q <= s2_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_bf16_addsub_pipe.sv
// Bench for bf16_addsub_pipe: vector table with hand-derived results, a scoreboard
// queue filled on input transfers and drained on output transfers, and hand sequences
// for latency, throughput, back-pressure and mid-stream reset.

module tb_bf16_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_op;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [7:0]  out_tag;

    always #5 clk = ~clk;

    bf16_addsub_pipe #(
        .TAG_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_op    (in_op),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_tag  (out_tag)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] sum;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic [7:0]  tag;
    } exp_t;

    localparam int NVEC = 15;

    vec_t        vecs[NVEC];
    exp_t        sb[$];
    exp_t        head;
    int          checks;
    int          failures;
    int          cyc;
    int          pop_cyc[8];
    logic [15:0] drv_sum;
    logic [7:0]  drv_tag;
    logic        hold_pending;
    logic [15:0] hold_sum;
    logic [7:0]  hold_tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepts the op.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op,
                        input logic [7:0] tag, input logic [15:0] expect_sum);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
        drv_sum  = expect_sum;
        drv_tag  = tag;
        for (n = 0; n < 100; n++) begin
            if (in_ready) break;
            tick();
        end
        if (n == 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: tag %h not accepted within 100 cycles", tag);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 100; n++) begin
            if (sb.size() == 0) break;
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        vecs[0]  = '{16'h3F80, 16'h4000, 1'b0, 16'h4040};  // 1 + 2 = 3
        vecs[1]  = '{16'h3F80, 16'h3FC0, 1'b1, 16'hBF00};  // 1 - 1.5 = -0.5
        vecs[2]  = '{16'h3F80, 16'h3F80, 1'b1, 16'h0000};  // exact cancel
        vecs[3]  = '{16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80};  // overflow to +inf
        vecs[4]  = '{16'h3F80, 16'h3A80, 1'b0, 16'h3F80};  // shift of 10 drops b
        vecs[5]  = '{16'h4000, 16'h4000, 1'b0, 16'h4080};  // carry out
        vecs[6]  = '{16'h3F80, 16'h4000, 1'b1, 16'hBF80};  // 1 - 2 = -1
        vecs[7]  = '{16'hBF80, 16'hBF80, 1'b0, 16'hC000};  // -1 + -1 = -2
        vecs[8]  = '{16'h3F80, 16'h3FC0, 1'b0, 16'h4020};  // 1 + 1.5 = 2.5
        vecs[9]  = '{16'h0100, 16'h00C0, 1'b1, 16'h0000};  // underflow to zero
        vecs[10] = '{16'h4040, 16'h3E00, 1'b1, 16'h4038};  // 3 - 0.125 = 2.875
        vecs[11] = '{16'h4000, 16'hBF80, 1'b0, 16'h3F80};  // 2 + -1 = 1
        vecs[12] = '{16'h3F80, 16'hBF80, 1'b1, 16'h4000};  // 1 - -1 = 2
        vecs[13] = '{16'hFF7F, 16'hFF7F, 1'b0, 16'hFF80};  // overflow to -inf
        vecs[14] = '{16'h0001, 16'h0001, 1'b0, 16'h0000};  // subnormals underflow

        checks       = 0;
        failures     = 0;
        cyc          = 0;
        hold_pending = 1'b0;
        hold_sum     = 16'h0;
        hold_tag     = 8'h0;
        drv_sum      = 16'h0;
        drv_tag      = 8'h0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_a         = 16'h0;
        in_b         = 16'h0;
        in_op        = 1'b0;
        in_tag       = 8'h0;
        out_ready    = 1'b1;
        for (int i = 0; i < 8; i++) pop_cyc[i] = 0;

        // Scoreboard monitor: pop on output transfer first, then push on input transfer.
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (rst) begin
                    sb.delete();
                    hold_pending = 1'b0;
                end else begin
                    check("in_ready_flow", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
                    if (out_valid && !out_ready) begin
                        if (hold_pending) begin
                            check("stall_hold_sum", {16'd0, out_sum}, {16'd0, hold_sum});
                            check("stall_hold_tag", {24'd0, out_tag}, {24'd0, hold_tag});
                        end
                        hold_pending = 1'b1;
                        hold_sum     = out_sum;
                        hold_tag     = out_tag;
                    end else begin
                        hold_pending = 1'b0;
                    end
                    if (out_valid && out_ready) begin
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_output: tag %h sum %h, required no output",
                                     out_tag, out_sum);
                        end else begin
                            head = sb.pop_front();
                            check("result_sum", {16'd0, out_sum}, {16'd0, head.sum});
                            check("result_tag", {24'd0, out_tag}, {24'd0, head.tag});
                            if (out_tag >= 8'h10 && out_tag < 8'h18) pop_cyc[out_tag - 8'h10] = cyc;
                        end
                    end
                    if (in_valid && in_ready) sb.push_back('{drv_sum, drv_tag});
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_sum", {16'd0, out_sum}, 32'd0);
        check("reset_out_tag", {24'd0, out_tag}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Latency: result appears exactly three edges after acceptance
        send(16'h3F80, 16'h4000, 1'b0, 8'h01, 16'h4040);
        @(negedge clk);
        check("latency_c1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_c2_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_c3_valid", {31'd0, out_valid}, 32'd1);
        check("latency_c3_sum", {16'd0, out_sum}, 32'h4040);
        tick();
        drain();

        // Vector table, back-to-back
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op, 8'(8'h40 + i), vecs[i].sum);
        end
        drain();

        // Full-rate burst: 8 results on consecutive cycles
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op, 8'(8'h10 + i), vecs[i].sum);
        end
        drain();
        check("burst_span", pop_cyc[7] - pop_cyc[0], 32'd7);

        // Same stream with 4 cycles of back-pressure mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(vecs[i].a, vecs[i].b, vecs[i].op, 8'(8'h20 + i), vecs[i].sum);
                end
            end
            begin
                repeat (5) tick();
                out_ready = 1'b0;
                tick();
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three ops in flight: none of them may emerge
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op, 8'(8'hA0 + i), vecs[i].sum);
        end
        rst = 1'b1;
        tick();
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_out_sum", {16'd0, out_sum}, 32'd0);
        check("flush_out_tag", {24'd0, out_tag}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        check("flush_quiet", {31'd0, out_valid}, 32'd0);

        // Recovery after the flush
        send(vecs[8].a, vecs[8].b, vecs[8].op, 8'h77, vecs[8].sum);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
